// File: rtl/dram_bridge_arb.sv
// rtl/dram_bridge_arb.sv - round-robin arbiter for NUM_CH DRAM requesters onto one AXI4-Lite master; optional watchdog via BRIDGE_TIMEOUT_EN
module dram_bridge_arb #(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 17,
  parameter int unsigned BASE_ADDR = 'h10000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*8-1:0]        ch_id,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_out_valid,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_err,
  output logic                       ar_valid,
  output logic [ADDR_W-1:0]          ar_addr,
  input  logic                       ar_ready,
  input  logic                       r_valid,
  input  logic [DATA_W-1:0]          r_data,
  input  logic [1:0]                 r_resp,
  output logic                       r_ready,
  output logic                       aw_valid,
  output logic [ADDR_W-1:0]          aw_addr,
  input  logic                       aw_ready,
  output logic                       w_valid,
  output logic [DATA_W-1:0]          w_data,
  input  logic                       w_ready,
  input  logic                       b_valid,
  input  logic [1:0]                 b_resp,
  output logic                       b_ready
);

  localparam int                PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0]       L_BASE32 = 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_BASE   = L_BASE32[ADDR_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_AR = 3'd1,
    S_RD_R  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_W  = 3'd4,
    S_WR_B  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_CH-1:0]   r_pend;
  logic [NUM_CH-1:0]   r_req_wr;
  logic [7:0]          r_req_id    [NUM_CH];
  logic [DATA_W-1:0]   r_req_wdata [NUM_CH];

  logic [PTR_W-1:0]    r_txn_ch;
  logic [ADDR_W-1:0]   r_txn_addr;
  logic [DATA_W-1:0]   r_txn_wdata;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic [NUM_CH-1:0]   w_req;
  logic                w_gnt_found;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_sel_wr;
  logic [7:0]          w_sel_id;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_grant;
  logic                w_wdog_hit;
  int                  w_dist;
  int                  w_best;

  // A pulse arriving this cycle is eligible immediately, so capture and grant can coincide.
  assign w_req   = r_pend | ch_valid;
  assign w_grant = (r_state == S_IDLE) && w_gnt_found;

  // Round-robin pick: the requesting channel nearest at/after the pointer wins; fields come from
  // the latched copy when pending, otherwise straight from the ports.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_best      = NUM_CH;
    w_dist      = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_dist = (c + NUM_CH - int'(r_ptr)) % NUM_CH;
      if (w_req[c] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_gnt_found = 1'b1;
        w_gnt_idx   = PTR_W'(c);
      end
    end
    w_sel_wr    = ch_write[w_gnt_idx];
    w_sel_id    = ch_id[int'(w_gnt_idx)*8 +: 8];
    w_sel_wdata = ch_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
    if (r_pend[w_gnt_idx]) begin
      w_sel_wr    = r_req_wr[w_gnt_idx];
      w_sel_id    = r_req_id[w_gnt_idx];
      w_sel_wdata = r_req_wdata[w_gnt_idx];
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_hs;

  assign w_hs = (ar_valid && ar_ready) || (r_ready && r_valid) || (aw_valid && aw_ready) ||
                (w_valid && w_ready) || (b_ready && b_valid);
  assign w_wdog_hit = (r_state != S_IDLE) && (r_state != S_DONE) && !w_hs &&
                      (r_wdog == 8'(TIMEOUT - 1));

  // Watchdog: counts stalled cycles while a transaction waits on the slave, restarts on any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_DONE) || w_hs) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 8'd1;
    end
  end
`else
  // No watchdog: the bridge waits on the slave indefinitely; TIMEOUT only matters when built in.
  assign w_wdog_hit = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: one AXI phase per state, each advancing on its own handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_found) w_state_nxt = w_sel_wr ? S_WR_AW : S_RD_AR;
      S_RD_AR: if (ar_ready)    w_state_nxt = S_RD_R;
      S_RD_R:  if (r_valid)     w_state_nxt = S_DONE;
      S_WR_AW: if (aw_ready)    w_state_nxt = S_WR_W;
      S_WR_W:  if (w_ready)     w_state_nxt = S_WR_B;
      S_WR_B:  if (b_valid)     w_state_nxt = S_DONE;
      S_DONE:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
    if (w_wdog_hit) w_state_nxt = S_DONE;
  end

  // Request capture and RR pointer; a pulse on an already-pending channel is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_pend   <= '0;
      r_req_wr <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_req_id[c]    <= '0;
        r_req_wdata[c] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_ptr <= (w_gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ((r_state == S_DONE) && (r_txn_ch == PTR_W'(c))) begin
          r_pend[c] <= 1'b0;
        end else if (ch_valid[c] && !r_pend[c]) begin
          r_pend[c]      <= 1'b1;
          r_req_wr[c]    <= ch_write[c];
          r_req_id[c]    <= ch_id[c*8 +: 8];
          r_req_wdata[c] <= ch_wdata[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Transaction context latched at grant, response latched at the final handshake or watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_ch    <= '0;
      r_txn_addr  <= '0;
      r_txn_wdata <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_txn_ch    <= w_gnt_idx;
        r_txn_addr  <= L_BASE + ADDR_W'({w_sel_id, 3'b000});
        r_txn_wdata <= w_sel_wdata;
      end
      if (w_wdog_hit) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end else if ((r_state == S_RD_R) && r_valid) begin
        r_rsp_data <= r_data;
        r_rsp_err  <= (r_resp != 2'b00);
      end else if ((r_state == S_WR_B) && b_valid) begin
        r_rsp_data <= r_txn_wdata;
        r_rsp_err  <= (b_resp != 2'b00);
      end
    end
  end

  // Outputs decoded from state so reset clears every valid/ready at once.
  always_comb begin
    ar_valid     = (r_state == S_RD_AR);
    r_ready      = (r_state == S_RD_R);
    aw_valid     = (r_state == S_WR_AW);
    w_valid      = (r_state == S_WR_W);
    b_ready      = (r_state == S_WR_B);
    ar_addr      = r_txn_addr;
    aw_addr      = r_txn_addr;
    w_data       = r_txn_wdata;
    ch_out_valid = '0;
    ch_rdata     = '0;
    ch_err       = '0;
    if (r_state == S_DONE) begin
      ch_out_valid[r_txn_ch]                     = 1'b1;
      ch_rdata[int'(r_txn_ch)*DATA_W +: DATA_W]  = r_rsp_data;
      ch_err[r_txn_ch]                           = r_rsp_err;
    end
  end

endmodule
